// File: rtl/hm_pkg.sv
// Shared definitions for the host-memory completion receiver: CplD type code, FSM encodings,
// TLP header field positions and the decoded-header record.
// Latency: n/a (package). Backpressure: n/a.
package hm_pkg;

    localparam int          HM_DW_PAGE       = 1024;
    localparam logic [6:0]  HM_CPLD_FMT_TYPE = 7'h4A;

    typedef enum logic [1:0] {
        HM_CPL_IDLE = 2'd0,
        HM_CPL_HDR  = 2'd1,
        HM_CPL_DATA = 2'd2,
        HM_CPL_DROP = 2'd3
    } hm_cpl_state_e;

    // DW0 fields
    localparam int HM_DW0_FT_MSB  = 30;
    localparam int HM_DW0_FT_LSB  = 24;
    localparam int HM_DW0_LEN_MSB = 9;
    localparam int HM_DW0_LEN_LSB = 0;
    // DW1 fields
    localparam int HM_DW1_STS_MSB = 15;
    localparam int HM_DW1_STS_LSB = 13;
    localparam int HM_DW1_BC_MSB  = 11;
    localparam int HM_DW1_BC_LSB  = 0;
    // DW2 fields
    localparam int HM_DW2_RID_MSB = 31;
    localparam int HM_DW2_RID_LSB = 16;

    // Result of decoding the first header beat of a completion.
    typedef struct packed {
        logic        accept;  // CplD, successful, link up, page armed, fits in byte count
        logic        last;    // this completion ends the page
        logic [10:0] len;     // payload DWs, 1..1024
        logic [9:0]  ptr;     // DW offset of the first payload DW within the page
    } hm_cpl_hdr_t;

endpackage

// File: rtl/hm_cpl_hdr_dec.sv
// Combinational decode of completion DW0/DW1 into accept/length/last/start pointer.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: dw0_i/dw1_i header DWs, lnk_up_i/armed_i qualifiers, hdr_o decoded record.
module hm_cpl_hdr_dec
    import hm_pkg::*;
(
    input  logic [31:0] dw0_i,
    input  logic [31:0] dw1_i,
    input  logic        lnk_up_i,
    input  logic        armed_i,
    output hm_cpl_hdr_t hdr_o
);

    logic [6:0]  ft;
    logic [2:0]  sts;
    logic [9:0]  len_raw;
    logic [11:0] bc_raw;
    logic [10:0] len;
    logic [12:0] bc;
    logic [12:0] len_bytes;
    logic [11:0] neg_bc;

    assign ft      = dw0_i[HM_DW0_FT_MSB:HM_DW0_FT_LSB];
    assign len_raw = dw0_i[HM_DW0_LEN_MSB:HM_DW0_LEN_LSB];
    assign sts     = dw1_i[HM_DW1_STS_MSB:HM_DW1_STS_LSB];
    assign bc_raw  = dw1_i[HM_DW1_BC_MSB:HM_DW1_BC_LSB];

    // A zero length field means 1024 DWs, a zero byte count means 4096 bytes.
    assign len       = (len_raw == 10'd0) ? 11'd1024 : {1'b0, len_raw};
    assign bc        = (bc_raw == 12'd0) ? 13'd4096 : {1'b0, bc_raw};
    assign len_bytes = {len[10:0], 2'b00};

    // Byte count is bytes remaining to the end of the page, so the start offset
    // is 4096 - bc; the modulo-4096 negation also maps bc=4096 to offset 0.
    assign neg_bc = 12'd0 - bc_raw;

    assign hdr_o.accept = (ft == HM_CPLD_FMT_TYPE) && (sts == 3'd0) && lnk_up_i && armed_i
                          && (len_bytes <= bc);
    assign hdr_o.last   = (len_bytes == bc);
    assign hdr_o.len    = len;
    assign hdr_o.ptr    = neg_bc[11:2];

    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{dw0_i[31], dw0_i[23:10], dw1_i[31:16], dw1_i[12]};

endmodule

// File: rtl/hm_cpl_rx.sv
// Completion receive engine: parses CplD TLPs from the 64-bit Rx TRN stream and writes payload DWs
// into the low/high page memories; pulses rx_memory_read when the last completion of the page lands.
// Latency: writes/pulse/count registered, valid one cycle after the beat. Backpressure: never (dst_rdy low out of reset).
// Ports: trn_* Rx TRN interface, cfg_* own requester ID, rx_start arm pulse, mem_l_*/mem_h_* write ports,
// rx_memory_read page-done pulse, stat_trn_cpt_rx accepted CplD count, stat_state FSM state.
module hm_cpl_rx
    import hm_pkg::*;
#(
    parameter int DW_PAGE = HM_DW_PAGE
) (
    input  logic        trn_clk,
    input  logic        sys_rst,
    input  logic        trn_lnk_up_n,
    input  logic [63:0] trn_rd,
    input  logic        trn_rrem_n,
    input  logic        trn_rsof_n,
    input  logic        trn_reof_n,
    input  logic        trn_rsrc_rdy_n,
    input  logic        trn_rsrc_dsc_n,
    input  logic        trn_rerrfwd_n,
    input  logic [6:0]  trn_rbar_hit_n,
    output logic        trn_rdst_rdy_n,
    output logic        trn_rnp_ok_n,
    input  logic [7:0]  cfg_bus_number,
    input  logic [4:0]  cfg_device_number,
    input  logic [2:0]  cfg_function_number,
    input  logic        rx_start,
    output logic [9:0]  mem_l_addr,
    output logic [9:0]  mem_h_addr,
    output logic [31:0] mem_l_data,
    output logic [31:0] mem_h_data,
    output logic        mem_l_we,
    output logic        mem_h_we,
    output logic        rx_memory_read,
    output logic [31:0] stat_trn_cpt_rx,
    output logic [1:0]  stat_state
);

    localparam int PTR_W = $clog2(DW_PAGE);

    hm_cpl_state_e    state_q, state_d;
    logic             armed_q, armed_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [10:0]      rem_q, rem_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             dst_rdy_n_q;
    logic             l_we_q, l_we_d, h_we_q, h_we_d;
    logic [9:0]       l_addr_q, l_addr_d, h_addr_q, h_addr_d;
    logic [31:0]      l_dat_q, l_dat_d, h_dat_q, h_dat_d;
    logic             pulse_q, pulse_d;

    hm_cpl_hdr_t      hdr;
    logic             beat;
    logic             eof;
    logic             beat_err;
    logic             rid_ok;
    logic             w0_en, w1_en;
    logic [31:0]      w0_dat, w1_dat;
    logic             tlp_end;
    logic [PTR_W-1:0] ptr1;

    hm_cpl_hdr_dec u_hdr_dec (
        .dw0_i    (trn_rd[63:32]),
        .dw1_i    (trn_rd[31:0]),
        .lnk_up_i (~trn_lnk_up_n),
        .armed_i  (armed_q),
        .hdr_o    (hdr)
    );

    assign beat     = ~trn_rsrc_rdy_n & ~dst_rdy_n_q;
    assign eof      = ~trn_reof_n;
    assign beat_err = ~trn_rerrfwd_n;
    // Requester ID lives in DW2, which is the upper half of the header beat.
    assign rid_ok   = trn_rd[32+HM_DW2_RID_MSB:32+HM_DW2_RID_LSB]
                      == {cfg_bus_number, cfg_device_number, cfg_function_number};
    // Second DW of a beat always sits one DW after the first, so in the other memory.
    assign ptr1     = ptr_q + PTR_W'(1);

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        last_d   = last_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        l_we_d   = 1'b0;
        h_we_d   = 1'b0;
        l_addr_d = l_addr_q;
        h_addr_d = h_addr_q;
        l_dat_d  = l_dat_q;
        h_dat_d  = h_dat_q;
        pulse_d  = 1'b0;
        w0_en    = 1'b0;
        w1_en    = 1'b0;
        w0_dat   = trn_rd[63:32];
        w1_dat   = trn_rd[31:0];
        tlp_end  = 1'b0;

        if (trn_lnk_up_n) begin
            state_d = HM_CPL_IDLE;
        end else if (beat) begin
            if (!trn_rsrc_dsc_n) begin
                // Discontinue: abandon the TLP, keep what was written, no count or pulse.
                state_d = HM_CPL_IDLE;
            end else begin
                case (state_q)
                    HM_CPL_IDLE: begin
                        if (!trn_rsof_n) begin
                            if (hdr.accept) begin
                                state_d = HM_CPL_HDR;
                                ptr_d   = hdr.ptr[PTR_W-1:0];
                                rem_d   = hdr.len;
                                last_d  = hdr.last;
                                err_d   = beat_err;
                            end else begin
                                state_d = eof ? HM_CPL_IDLE : HM_CPL_DROP;
                            end
                        end
                    end
                    HM_CPL_HDR: begin
                        err_d = err_q | beat_err;
                        if (!rid_ok) begin
                            state_d = eof ? HM_CPL_IDLE : HM_CPL_DROP;
                        end else begin
                            // Lower half of the header beat carries payload D0.
                            w0_en  = ~trn_rrem_n & (rem_q != 11'd0);
                            w0_dat = trn_rd[31:0];
                            if (eof) begin
                                state_d = HM_CPL_IDLE;
                                tlp_end = 1'b1;
                            end else begin
                                state_d = HM_CPL_DATA;
                            end
                        end
                    end
                    HM_CPL_DATA: begin
                        err_d = err_q | beat_err;
                        w0_en = (rem_q != 11'd0);
                        w1_en = ~trn_rrem_n & (rem_q > 11'd1);
                        if (eof) begin
                            state_d = HM_CPL_IDLE;
                            tlp_end = 1'b1;
                        end
                    end
                    HM_CPL_DROP: begin
                        if (eof) begin
                            state_d = HM_CPL_IDLE;
                        end
                    end
                    default: state_d = HM_CPL_IDLE;
                endcase
            end
        end

        if (w0_en) begin
            if (ptr_q[0]) begin
                h_we_d   = 1'b1;
                h_addr_d = {1'b0, ptr_q[PTR_W-1:1]};
                h_dat_d  = w0_dat;
            end else begin
                l_we_d   = 1'b1;
                l_addr_d = {1'b0, ptr_q[PTR_W-1:1]};
                l_dat_d  = w0_dat;
            end
            ptr_d = ptr_q + PTR_W'(1);
            rem_d = rem_q - 11'd1;
        end
        if (w1_en) begin
            if (ptr1[0]) begin
                h_we_d   = 1'b1;
                h_addr_d = {1'b0, ptr1[PTR_W-1:1]};
                h_dat_d  = w1_dat;
            end else begin
                l_we_d   = 1'b1;
                l_addr_d = {1'b0, ptr1[PTR_W-1:1]};
                l_dat_d  = w1_dat;
            end
            ptr_d = ptr_q + PTR_W'(2);
            rem_d = rem_q - 11'd2;
        end

        if (tlp_end) begin
            cnt_d = cnt_q + 32'd1;
            if (last_q && !(err_q | beat_err)) begin
                pulse_d = 1'b1;
                armed_d = 1'b0;
            end
        end
        // Arming wins over the disarm of a page that completes in the same cycle.
        if (rx_start) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge trn_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= HM_CPL_IDLE;
            armed_q     <= 1'b0;
            ptr_q       <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            dst_rdy_n_q <= 1'b1;
            l_we_q      <= 1'b0;
            h_we_q      <= 1'b0;
            l_addr_q    <= '0;
            h_addr_q    <= '0;
            l_dat_q     <= '0;
            h_dat_q     <= '0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            last_q      <= last_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            dst_rdy_n_q <= 1'b0;
            l_we_q      <= l_we_d;
            h_we_q      <= h_we_d;
            l_addr_q    <= l_addr_d;
            h_addr_q    <= h_addr_d;
            l_dat_q     <= l_dat_d;
            h_dat_q     <= h_dat_d;
            pulse_q     <= pulse_d;
        end
    end

    assign trn_rdst_rdy_n  = dst_rdy_n_q;
    assign trn_rnp_ok_n    = dst_rdy_n_q;
    assign mem_l_we        = l_we_q;
    assign mem_h_we        = h_we_q;
    assign mem_l_addr      = l_addr_q;
    assign mem_h_addr      = h_addr_q;
    assign mem_l_data      = l_dat_q;
    assign mem_h_data      = h_dat_q;
    assign rx_memory_read  = pulse_q;
    assign stat_trn_cpt_rx = cnt_q;
    assign stat_state      = state_q;

    logic unused_bar;
    assign unused_bar = ^trn_rbar_hit_n;

endmodule

// File: tb/tb_hm_cpl_rx.sv
// Directed bench for hm_cpl_rx: per-beat vector table plus whole-page and corner-case sequences.
module tb_hm_cpl_rx;

    localparam logic [15:0] RID_OK  = 16'h121D;  // bus 12, dev 3, fn 5
    localparam logic [15:0] RID_BAD = 16'h121C;

    logic        trn_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        trn_lnk_up_n = 1'b0;
    logic [63:0] trn_rd = '0;
    logic        trn_rrem_n = 1'b0;
    logic        trn_rsof_n = 1'b1;
    logic        trn_reof_n = 1'b1;
    logic        trn_rsrc_rdy_n = 1'b1;
    logic        trn_rsrc_dsc_n = 1'b1;
    logic        trn_rerrfwd_n = 1'b1;
    logic [6:0]  trn_rbar_hit_n = 7'h7F;
    logic        trn_rdst_rdy_n, trn_rnp_ok_n;
    logic        rx_start = 1'b0;
    logic [9:0]  mem_l_addr, mem_h_addr;
    logic [31:0] mem_l_data, mem_h_data;
    logic        mem_l_we, mem_h_we;
    logic        rx_memory_read;
    logic [31:0] stat_trn_cpt_rx;
    logic [1:0]  stat_state;

    hm_cpl_rx #(.DW_PAGE(1024)) dut (
        .trn_clk(trn_clk), .sys_rst(sys_rst), .trn_lnk_up_n(trn_lnk_up_n),
        .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
        .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rerrfwd_n(trn_rerrfwd_n),
        .trn_rbar_hit_n(trn_rbar_hit_n), .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_rnp_ok_n(trn_rnp_ok_n),
        .cfg_bus_number(8'h12), .cfg_device_number(5'h03), .cfg_function_number(3'h5),
        .rx_start(rx_start),
        .mem_l_addr(mem_l_addr), .mem_h_addr(mem_h_addr), .mem_l_data(mem_l_data), .mem_h_data(mem_h_data),
        .mem_l_we(mem_l_we), .mem_h_we(mem_h_we), .rx_memory_read(rx_memory_read),
        .stat_trn_cpt_rx(stat_trn_cpt_rx), .stat_state(stat_state)
    );

    always #5 trn_clk = ~trn_clk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          pulse_cnt = 0;
    logic [31:0] mdl_l [0:1023];
    logic [31:0] mdl_h [0:1023];

    // Page memory model and pulse counter, sampled on the falling edge.
    always @(negedge trn_clk) begin
        if (mem_l_we) mdl_l[mem_l_addr] <= mem_l_data;
        if (mem_h_we) mdl_h[mem_h_addr] <= mem_h_data;
        if (rx_memory_read) pulse_cnt <= pulse_cnt + 1;
    end

    function automatic logic [31:0] dw0(input logic [6:0] ft, input logic [9:0] len);
        return {1'b0, ft, 14'd0, len};
    endfunction
    function automatic logic [31:0] dw1(input logic [2:0] st, input logic [11:0] bc);
        return {16'hBEEF, st, 1'b0, bc};
    endfunction
    function automatic logic [31:0] dw2(input logic [15:0] rid);
        return {rid, 8'h5A, 8'h00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic rrem_n, input logic sof, input logic eof,
                        input logic dsc, input logic ef);
        @(negedge trn_clk);
        trn_rd         = d;
        trn_rrem_n     = rrem_n;
        trn_rsof_n     = ~sof;
        trn_reof_n     = ~eof;
        trn_rsrc_dsc_n = ~dsc;
        trn_rerrfwd_n  = ~ef;
        trn_rsrc_rdy_n = 1'b0;
        @(posedge trn_clk);
    endtask

    task automatic idle_bus();
        @(negedge trn_clk);
        trn_rsrc_rdy_n = 1'b1;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        trn_rerrfwd_n  = 1'b1;
    endtask

    task automatic arm();
        @(negedge trn_clk);
        rx_start = 1'b1;
        @(negedge trn_clk);
        rx_start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge trn_clk);
    endtask

    // Sends a completion whose payload DW k is base+k; dsc_beat >= 0 discontinues on that beat.
    task automatic send_cpl(input logic [6:0] ft, input logic [2:0] st, input int n, input logic [11:0] bc,
                            input logic [15:0] rid, input logic [31:0] base, input int dsc_beat, input logic ef);
        int   idx;
        int   bi;
        logic [9:0] len;
        len = n[9:0];
        beat({dw0(ft, len), dw1(st, bc)}, 1'b0, 1'b1, 1'b0, dsc_beat == 0, 1'b0);
        if (dsc_beat == 0) return;
        beat({dw2(rid), base}, 1'b0, 1'b0, n == 1, dsc_beat == 1, ef);
        if (dsc_beat == 1) return;
        idx = 1;
        bi  = 2;
        while (idx < n) begin
            beat({32'(base + idx), 32'(base + idx + 1)}, (idx + 1 < n) ? 1'b0 : 1'b1, 1'b0,
                 idx + 2 >= n, dsc_beat == bi, 1'b0);
            if (dsc_beat == bi) return;
            idx += 2;
            bi++;
        end
    endtask

    task automatic check_page(input string name, input logic [31:0] base);
        int bad;
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (mdl_l[k] !== 32'(base + 2 * k)) bad++;
            if (mdl_h[k] !== 32'(base + 2 * k + 1)) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdst_rdy_n"}, {31'd0, trn_rdst_rdy_n}, 1);
        check({tag, "_rnp_ok_n"}, {31'd0, trn_rnp_ok_n}, 1);
        check({tag, "_state"}, {30'd0, stat_state}, 0);
        check({tag, "_we"}, {30'd0, mem_l_we, mem_h_we}, 0);
        check({tag, "_l_addr_data"}, {22'd0, mem_l_addr} | mem_l_data, 0);
        check({tag, "_h_addr_data"}, {22'd0, mem_h_addr} | mem_h_data, 0);
        check({tag, "_pulse"}, {31'd0, rx_memory_read}, 0);
        check({tag, "_cnt"}, stat_trn_cpt_rx, 0);
    endtask

    typedef struct {
        logic [63:0] rd;
        logic        rrem_n;
        logic        sof;
        logic        eof;
        logic [1:0]  e_state;
        logic        e_lwe;
        logic        e_hwe;
        logic [9:0]  e_addr;
        logic [31:0] e_data;
        logic        e_pulse;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] exp_cnt;
    int          p0;

    initial begin
        // Requester-ID mismatch on a 64 B final CplD: header accepted, then dropped.
        tbl[0]  = '{{dw0(7'h4A, 10'd16), dw1(3'd0, 12'd64)}, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0};
        tbl[1]  = '{{dw2(RID_BAD), 32'h0000_0000}, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0};
        tbl[2]  = '{64'h1111_1111_2222_2222, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0};
        tbl[3]  = '{64'h3333_3333_4444_4444, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0};
        // Unsupported-request status: dropped.
        tbl[4]  = '{{dw0(7'h4A, 10'd1), dw1(3'd1, 12'd4)}, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0};
        tbl[5]  = '{{dw2(RID_OK), 32'h0000_0005}, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0};
        // Memory write TLP: dropped.
        tbl[6]  = '{{dw0(7'h40, 10'd1), 32'h0000_1000}, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0};
        tbl[7]  = '{64'hAAAA_0000_0000_0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0};
        // Single-DW final completion, bc 4: DW offset 1023 -> mem_h word 511, page done.
        tbl[8]  = '{{dw0(7'h4A, 10'd1), dw1(3'd0, 12'd4)}, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0};
        tbl[9]  = '{{dw2(RID_OK), 32'hCAFE_0001}, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 10'd511, 32'hCAFE_0001, 1'b1};
        // Stray non-SOF beat while idle is ignored.
        tbl[10] = '{64'h5555_5555_6666_6666, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0};

        // Reset state
        repeat (3) @(posedge trn_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge trn_clk);
        sys_rst = 1'b0;
        @(posedge trn_clk);
        #1;
        check("rdst_rdy_after_reset", {31'd0, trn_rdst_rdy_n}, 0);
        check("rnp_ok_after_reset", {31'd0, trn_rnp_ok_n}, 0);
        exp_cnt = 32'd0;

        // Single 4096 B completion
        arm();
        p0 = pulse_cnt;
        send_cpl(7'h4A, 3'd0, 1024, 12'd0, RID_OK, 32'd0, -1, 1'b0);
        idle_bus();
        settle();
        exp_cnt = exp_cnt + 1;
        check_page("page4k_data", 32'd0);
        check("page4k_pulses", pulse_cnt - p0, 1);
        check("page4k_cnt", stat_trn_cpt_rx, exp_cnt);

        // 32 back-to-back 128 B completions covering the page
        arm();
        p0 = pulse_cnt;
        for (int i = 0; i < 32; i++) begin
            send_cpl(7'h4A, 3'd0, 32, 12'(4096 - 128 * i), RID_OK, 32'h1000_0000 + 32'(32 * i), -1, 1'b0);
            if (i == 30) begin
                #1;
                check("split_no_early_pulse", {31'd0, rx_memory_read}, 0);
            end
        end
        idle_bus();
        settle();
        exp_cnt = exp_cnt + 32;
        check_page("split_data", 32'h1000_0000);
        check("split_pulses", pulse_cnt - p0, 1);
        check("split_cnt", stat_trn_cpt_rx, exp_cnt);

        // Per-beat vector table
        arm();
        for (int v = 0; v < 11; v++) begin
            beat(tbl[v].rd, tbl[v].rrem_n, tbl[v].sof, tbl[v].eof, 1'b0, 1'b0);
            #1;
            check($sformatf("vec%0d_state", v), {30'd0, stat_state}, {30'd0, tbl[v].e_state});
            check($sformatf("vec%0d_we", v), {30'd0, mem_l_we, mem_h_we}, {30'd0, tbl[v].e_lwe, tbl[v].e_hwe});
            check($sformatf("vec%0d_pulse", v), {31'd0, rx_memory_read}, {31'd0, tbl[v].e_pulse});
            if (tbl[v].e_hwe) begin
                check($sformatf("vec%0d_h_addr", v), {22'd0, mem_h_addr}, {22'd0, tbl[v].e_addr});
                check($sformatf("vec%0d_h_data", v), mem_h_data, tbl[v].e_data);
            end
        end
        idle_bus();
        settle();
        exp_cnt = exp_cnt + 1;
        check("table_cnt", stat_trn_cpt_rx, exp_cnt);

        // Poisoned final completion: written and counted, no pulse
        arm();
        p0 = pulse_cnt;
        send_cpl(7'h4A, 3'd0, 1, 12'd4, RID_OK, 32'h0000_0077, -1, 1'b1);
        idle_bus();
        settle();
        exp_cnt = exp_cnt + 1;
        check("errfwd_write", mdl_h[511], 32'h0000_0077);
        check("errfwd_pulses", pulse_cnt - p0, 0);
        check("errfwd_cnt", stat_trn_cpt_rx, exp_cnt);

        // Discontinue mid-TLP of the final completion, then resend
        send_cpl(7'h4A, 3'd0, 32, 12'd128, RID_OK, 32'h2000_0000, 3, 1'b0);
        #1;
        check("dsc_state", {30'd0, stat_state}, 0);
        idle_bus();
        settle();
        check("dsc_pulses", pulse_cnt - p0, 0);
        check("dsc_cnt", stat_trn_cpt_rx, exp_cnt);
        send_cpl(7'h4A, 3'd0, 32, 12'd128, RID_OK, 32'h2000_0000, -1, 1'b0);
        idle_bus();
        settle();
        exp_cnt = exp_cnt + 1;
        check("resend_pulses", pulse_cnt - p0, 1);
        check("resend_cnt", stat_trn_cpt_rx, exp_cnt);
        check("resend_last_dw", mdl_h[511], 32'h2000_001F);

        // Asynchronous reset in the middle of a data phase
        arm();
        p0 = pulse_cnt;
        beat({dw0(7'h4A, 10'd0), dw1(3'd0, 12'd0)}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        beat({dw2(RID_OK), 32'h3000_0000}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat({32'h3000_0001, 32'h3000_0002}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("pre_reset_data_state", {30'd0, stat_state}, 2);
        #1;
        sys_rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        idle_bus();
        @(negedge trn_clk);
        sys_rst = 1'b0;
        exp_cnt = 32'd0;
        settle();
        send_cpl(7'h4A, 3'd0, 1, 12'd4, RID_OK, 32'h0000_0099, -1, 1'b0);
        idle_bus();
        settle();
        check("unarmed_pulses", pulse_cnt - p0, 0);
        check("unarmed_cnt", stat_trn_cpt_rx, exp_cnt);
        arm();
        send_cpl(7'h4A, 3'd0, 1, 12'd4, RID_OK, 32'h0000_00AA, -1, 1'b0);
        idle_bus();
        settle();
        exp_cnt = exp_cnt + 1;
        check("rearmed_pulses", pulse_cnt - p0, 1);
        check("rearmed_cnt", stat_trn_cpt_rx, exp_cnt);
        check("rearmed_write", mdl_h[511], 32'h0000_00AA);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
